fpu_mul16_iter: RTL and testbench
=================================

# fpu_mul16_iter

Iterative FP16 significand multiplier. It sits directly upstream of `fpuNormalizer16` (instantiated with `PFW = 20`) and feeds it. The block accepts two `fp16_t` operands over a valid/ready handshake and forms the 11×11-bit significand product with a shift-add FSM. It then presents the unnormalized sign, 2-bit integer, 20-bit fraction, biased exponent and sticky bit, held until the consumer accepts them.

## Interface
- `LAT_BITS`, default 4: width of the iteration counter.
- `clk` input 1: sole clock.
- `rst` input 1: reset, asynchronous and active-high.
- `inValid` input 1: operands `mulIn1`/`mulIn2` are valid.
- `inReady` output 1: block can accept operands.
- `mulIn1`, `mulIn2` input 16 (`fp16_t`): operands.
- `outValid` output 1: result fields are valid.
- `outReady` input 1: downstream consumes the result.
- `unnormSign` output 1: product sign.
- `unnormInt` output 2: product bits [21:20].
- `unnormFrac` output 20: product bits [19:0].
- `unnormExp` output `FP16_EXPW`: saturated biased exponent.
- `sticky` output 1: OR of product bits [8:0].
- `expOF` output 1: exponent overflow detected.
- `expUF` output 1: exponent underflow detected.

## Operation
- FSM states are IDLE, MUL and DONE.
- **IDLE:** `inReady = 1`.
  - On `inValid`, register the operands and compute `sign = s1 ^ s2`.
  - Form each significand as `{exp != 0, frac}`.
  - Compute the effective exponent as `exp == 0 ? 1 : exp`.
  - If either operand is zero (exp and frac both 0), go to DONE with an all-zero product.
  - Otherwise clear the accumulator, load the counter, and go to MUL.
- **MUL (radix-2, LSB-first):** each cycle performs one step.
  - If the multiplier LSB is 1, add the multiplicand into the 22-bit accumulator.
  - Shift the multiplier right and the multiplicand left.
  - Decrement the counter.
  - After the 11th step, go to DONE.
- **Exponent:** computed in 7-bit signed arithmetic as `e = e1 + e2 - 15`.
  - `e > 30`: `unnormExp = 30`, `expOF = 1`.
  - `e < 1`: `unnormExp = 0`, `expUF = 1`.
  - Otherwise `unnormExp = e[4:0]`.
- **Zero shortcut:** the exponent is 0 and both flags are 0.
- **DONE:** `outValid = 1`; all outputs are held stable.
  - On `outReady`, go to IDLE.
  - An accept is never taken in the same cycle as the DONE→IDLE transition.
- `inValid` is ignored outside IDLE. Operands are not required to stay stable after acceptance.
- NaN/Inf operands are not special-cased; exp 31 is treated as an ordinary exponent.

## Timing
- **Reset:** state = IDLE, `inReady = 1` (combinational from state), `outValid = 0`. All result outputs and flags are 0.
- **Latency, normal path:** accept at cycle 0, MUL during cycles 1–11, `outValid` first high at cycle 12.
- **Latency, zero shortcut:** `outValid` high at cycle 1.
- **Throughput:** at most one operation every 13 cycles under continuous `outReady`.
- **Backpressure:** `outValid` stays high and all outputs are frozen until `outReady` is sampled high.
- **Reset mid-operation:** abandons the operation immediately. No partial result becomes visible, and the block is ready the first cycle after deassertion.
- All outputs are registered; no combinational path from inputs to outputs except `inReady` from state.

## Configuration
- `FPU_MUL_RADIX4_EN` defined:
  - The MUL step uses Booth-free radix-4: add `0/1/2/3 × multiplicand`, consuming 2 multiplier bits per cycle.
  - The multiplier is zero-extended to 12 bits.
  - MUL takes 6 cycles; `outValid` at cycle 7.
- Not defined: radix-2, 11 MUL cycles, `outValid` at cycle 12.
- Results are bit-identical in both modes.

## Structure
- **Shared constants package:**
  - `fp16_t`, `FP16_EXPW`, `FP16_FRACW` (existing).
  - New `FP16_BIAS = 15`.
  - New `FP16_SIGW = 11`.
  - New `mulState_t` enum {IDLE, MUL, DONE}.
- **Sub-module** `fpuMulStep`: combinational single iteration.
  - Inputs: accumulator, multiplicand, multiplier.
  - Outputs: next accumulator, multiplicand, multiplier.
  - The radix is selected by the macro.
- Exponent logic and the FSM stay in the top module.

## Test plan
- 0x3C00 × 0x3C00 (1.0 × 1.0) → int=01, frac=0x00000, exp=15, sign=0, sticky=0, `outValid` at cycle 12 (7 with radix-4).
- 0x3E00 × 0x3E00 (1.5 × 1.5) → int=10, frac=0x40000, exp=15, sticky=0.
- 0x4000 × 0xC200 (2 × −3) → sign=1, int=01, frac=0x80000, exp=17.
- 0x0000 × 0x5555 → `outValid` at cycle 1, int=00, frac=0, exp=0, sign=0, flags 0.
- 0x7800 × 0x7800 → `expOF=1`, exp=30.
- 0x0400 × 0x0400 → `expUF=1`, exp=0.
- **Backpressure:** 0x3E00 × 0x3E00 with `outReady=0` for 5 cycles after `outValid`.
  - Outputs are unchanged and `inReady=0` throughout.
  - After accept: IDLE, and a new `inValid` is taken the following cycle.
- **Reset mid-MUL:** assert `rst` at cycle 5 → `outValid=0`, `inReady=1` immediately. The next operation gives a correct result.

Source files
------------

// File: rtl/fpu_mul16_iter_pkg.sv
// Shared FP16 constants, operand format and multiplier FSM states.
// FPU_MUL_RADIX4_EN selects the radix-4 iteration count.
package fpu_mul16_iter_pkg;

    localparam int FP16_EXPW  = 5;
    localparam int FP16_FRACW = 10;
    localparam int FP16_BIAS  = 15;
    localparam int FP16_SIGW  = 11;
    localparam int PROD_W     = 2 * FP16_SIGW;

`ifdef FPU_MUL_RADIX4_EN
    localparam int MUL_STEPS = 6;
`else
    localparam int MUL_STEPS = 11;
`endif

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXPW-1:0]  exp;
        logic [FP16_FRACW-1:0] frac;
    } fp16_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mulState_t;

endpackage

// File: rtl/fpu_mul16_iter_step.sv
// One shift-add iteration of the significand multiplier.
// FPU_MUL_RADIX4_EN: consume two multiplier bits per step instead of one.
module fpuMulStep
    import fpu_mul16_iter_pkg::*;
(
    input  logic [PROD_W-1:0]  acc,
    input  logic [PROD_W-1:0]  mcand,
    input  logic [FP16_SIGW:0] mplier,
    output logic [PROD_W-1:0]  acc_nxt,
    output logic [PROD_W-1:0]  mcand_nxt,
    output logic [FP16_SIGW:0] mplier_nxt
);

    logic [PROD_W-1:0] addend;

    // Select the partial product, accumulate it, advance both shifters
    always_comb begin
        addend = '0;
`ifdef FPU_MUL_RADIX4_EN
        unique case (mplier[1:0])
            2'd0: addend = '0;
            2'd1: addend = mcand;
            2'd2: addend = mcand << 1;
            2'd3: addend = mcand + (mcand << 1);
        endcase
        mcand_nxt  = mcand << 2;
        mplier_nxt = mplier >> 2;
`else
        if (mplier[0]) addend = mcand;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
`endif
        acc_nxt = acc + addend;
    end

endmodule

// File: rtl/fpu_mul16_iter.sv
// Iterative FP16 significand multiplier feeding the normalizer.
// FPU_MUL_RADIX4_EN: radix-4 iteration (6 MUL cycles instead of 11).
module fpu_mul16_iter
    import fpu_mul16_iter_pkg::*;
#(
    parameter int LAT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inValid,
    output logic                 inReady,
    input  fp16_t                mulIn1,
    input  fp16_t                mulIn2,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 unnormSign,
    output logic [1:0]           unnormInt,
    output logic [19:0]          unnormFrac,
    output logic [FP16_EXPW-1:0] unnormExp,
    output logic                 sticky,
    output logic                 expOF,
    output logic                 expUF
);

    mulState_t state, state_nxt;

    logic [PROD_W-1:0]   acc, acc_nxt;
    logic [PROD_W-1:0]   mcand, mcand_nxt;
    logic [FP16_SIGW:0]  mplier, mplier_nxt;
    logic [LAT_BITS-1:0] cnt;
    logic                sign_r;
    logic signed [6:0]   exp_r;

    logic [FP16_SIGW-1:0] sig_a, sig_b;
    logic [6:0]           eff_a, eff_b;
    logic signed [6:0]    exp_in;
    logic                 zero_in;
    logic                 last_step;

    assign sig_a   = {|mulIn1.exp, mulIn1.frac};
    assign sig_b   = {|mulIn2.exp, mulIn2.frac};
    assign eff_a   = (mulIn1.exp == '0) ? 7'd1 : {2'b00, mulIn1.exp};
    assign eff_b   = (mulIn2.exp == '0) ? 7'd1 : {2'b00, mulIn2.exp};
    assign exp_in  = $signed(eff_a + eff_b - 7'(FP16_BIAS));
    assign zero_in = (mulIn1.exp == '0 && mulIn1.frac == '0) ||
                     (mulIn2.exp == '0 && mulIn2.frac == '0);

    assign last_step = (cnt == LAT_BITS'(1));
    assign inReady   = (state == IDLE);

    fpuMulStep u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (inValid) state_nxt = zero_in ? DONE : MUL;
            MUL:  if (last_step) state_nxt = DONE;
            DONE: if (outReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            outValid   <= 1'b0;
            unnormSign <= 1'b0;
            unnormInt  <= '0;
            unnormFrac <= '0;
            unnormExp  <= '0;
            sticky     <= 1'b0;
            expOF      <= 1'b0;
            expUF      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inValid) begin
                        sign_r <= mulIn1.sign ^ mulIn2.sign;
                        exp_r  <= exp_in;
                        acc    <= '0;
                        mcand  <= {{(PROD_W-FP16_SIGW){1'b0}}, sig_a};
                        mplier <= {1'b0, sig_b};
                        cnt    <= LAT_BITS'(MUL_STEPS);
                        if (zero_in) begin
                            outValid   <= 1'b1;
                            unnormSign <= mulIn1.sign ^ mulIn2.sign;
                            unnormInt  <= '0;
                            unnormFrac <= '0;
                            unnormExp  <= '0;
                            sticky     <= 1'b0;
                            expOF      <= 1'b0;
                            expUF      <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt - 1'b1;
                    if (last_step) begin
                        outValid   <= 1'b1;
                        unnormSign <= sign_r;
                        unnormInt  <= acc_nxt[21:20];
                        unnormFrac <= acc_nxt[19:0];
                        sticky     <= |acc_nxt[8:0];
                        expOF      <= (exp_r > 7'sd30);
                        expUF      <= (exp_r < 7'sd1);
                        if (exp_r > 7'sd30)
                            unnormExp <= FP16_EXPW'(30);
                        else if (exp_r < 7'sd1)
                            unnormExp <= '0;
                        else
                            unnormExp <= exp_r[FP16_EXPW-1:0];
                    end
                end
                DONE: begin
                    if (outReady) outValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul16_iter.sv
// Directed self-checking bench for fpu_mul16_iter.
// Expected latency follows FPU_MUL_RADIX4_EN.
module tb_fpu_mul16_iter;
    import fpu_mul16_iter_pkg::*;

`ifdef FPU_MUL_RADIX4_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 12;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 inValid;
    logic                 inReady;
    logic [15:0]          mulIn1, mulIn2;
    logic                 outValid;
    logic                 outReady;
    logic                 unnormSign;
    logic [1:0]           unnormInt;
    logic [19:0]          unnormFrac;
    logic [FP16_EXPW-1:0] unnormExp;
    logic                 sticky, expOF, expUF;
    logic [30:0]          res;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // {sign, int, frac, exp, sticky, of, uf}
    assign res = {unnormSign, unnormInt, unnormFrac, unnormExp,
                  sticky, expOF, expUF};

    fpu_mul16_iter #(.LAT_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .inValid    (inValid),
        .inReady    (inReady),
        .mulIn1     (mulIn1),
        .mulIn2     (mulIn2),
        .outValid   (outValid),
        .outReady   (outReady),
        .unnormSign (unnormSign),
        .unnormInt  (unnormInt),
        .unnormFrac (unnormFrac),
        .unnormExp  (unnormExp),
        .sticky     (sticky),
        .expOF      (expOF),
        .expUF      (expUF)
    );

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        mulIn1  = a;
        mulIn2  = b;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        mulIn1  = 16'hFFFF;
        mulIn2  = 16'hA5A5;
        lat = 1;
        while (!outValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hs: outValid=%b inReady=%b want 0/1",
                     outValid, inReady);
        end
        n_cmp++;
        if (res !== 31'd0) begin
            n_bad++;
            $display("FAIL reset_res: got %h want 0", res);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset: outValid=%b inReady=%b want 0/1",
                     outValid, inReady);
        end
    endtask

    task automatic test_normal();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic [30:0] ve [5];
        int lat;
        va[0] = 16'h3C00; vb[0] = 16'h3C00;
        ve[0] = {1'b0, 2'b01, 20'h00000, 5'd15, 3'b000};
        va[1] = 16'h3E00; vb[1] = 16'h3E00;
        ve[1] = {1'b0, 2'b10, 20'h40000, 5'd15, 3'b000};
        va[2] = 16'h4000; vb[2] = 16'hC200;
        ve[2] = {1'b1, 2'b01, 20'h80000, 5'd17, 3'b000};
        va[3] = 16'h3C01; vb[3] = 16'h3C01;
        ve[3] = {1'b0, 2'b01, 20'h00801, 5'd15, 3'b100};
        va[4] = 16'h0001; vb[4] = 16'h3C00;
        ve[4] = {1'b0, 2'b00, 20'h00400, 5'd1, 3'b000};
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], lat);
            n_cmp++;
            if (lat !== LAT) begin
                n_bad++;
                $display("FAIL normal_lat[%0d]: got %0d want %0d", i, lat, LAT);
            end
            n_cmp++;
            if (res !== ve[i]) begin
                n_bad++;
                $display("FAIL normal_res[%0d]: got %h want %h", i, res, ve[i]);
            end
            retire();
            n_cmp++;
            if (outValid !== 1'b0 || inReady !== 1'b1) begin
                n_bad++;
                $display("FAIL normal_ret[%0d]: outValid=%b inReady=%b", i,
                         outValid, inReady);
            end
        end
    endtask

    task automatic test_exp_limits();
        logic [15:0] va [2];
        logic [30:0] ve [2];
        int lat;
        va[0] = 16'h7800;
        ve[0] = {1'b0, 2'b01, 20'h00000, 5'd30, 3'b010};
        va[1] = 16'h0400;
        ve[1] = {1'b0, 2'b01, 20'h00000, 5'd0, 3'b001};
        for (int i = 0; i < 2; i++) begin
            issue(va[i], va[i], lat);
            n_cmp++;
            if (lat !== LAT) begin
                n_bad++;
                $display("FAIL exp_lat[%0d]: got %0d want %0d", i, lat, LAT);
            end
            n_cmp++;
            if (res !== ve[i]) begin
                n_bad++;
                $display("FAIL exp_res[%0d]: got %h want %h", i, res, ve[i]);
            end
            retire();
        end
    endtask

    task automatic test_zero();
        logic [15:0] va [2];
        logic [15:0] vb [2];
        int lat;
        va[0] = 16'h0000; vb[0] = 16'h5555;
        va[1] = 16'h5555; vb[1] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            issue(va[i], vb[i], lat);
            n_cmp++;
            if (lat !== 1) begin
                n_bad++;
                $display("FAIL zero_lat[%0d]: got %0d want 1", i, lat);
            end
            n_cmp++;
            if (res !== 31'd0) begin
                n_bad++;
                $display("FAIL zero_res[%0d]: got %h want 0", i, res);
            end
            retire();
        end
    endtask

    task automatic test_backpressure();
        logic [30:0] e15;
        logic [30:0] e10;
        int lat;
        e15 = {1'b0, 2'b10, 20'h40000, 5'd15, 3'b000};
        e10 = {1'b0, 2'b01, 20'h00000, 5'd15, 3'b000};
        issue(16'h3E00, 16'h3E00, lat);
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++;
            $display("FAIL bp_lat: got %0d want %0d", lat, LAT);
        end
        mulIn1  = 16'h3C00;
        mulIn2  = 16'h3C00;
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (res !== e15 || outValid !== 1'b1 || inReady !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: res=%h v=%b r=%b want %h 1 0",
                         i, res, outValid, inReady, e15);
            end
        end
        retire();
        n_cmp++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_idle: outValid=%b inReady=%b want 0/1",
                     outValid, inReady);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        mulIn1  = 16'hFFFF;
        n_cmp++;
        if (inReady !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: inReady=%b want 0", inReady);
        end
        lat = 1;
        while (!outValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== LAT || res !== e10) begin
            n_bad++;
            $display("FAIL b2b_res: lat=%0d res=%h want %0d %h",
                     lat, res, LAT, e10);
        end
        retire();
    endtask

    task automatic test_reset_mid();
        logic [30:0] e;
        int lat;
        e = {1'b1, 2'b01, 20'h80000, 5'd17, 3'b000};
        mulIn1  = 16'h3E00;
        mulIn2  = 16'h3E00;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outValid !== 1'b0 || inReady !== 1'b1 || res !== 31'd0) begin
            n_bad++;
            $display("FAIL rst_mid: v=%b r=%b res=%h want 0 1 0",
                     outValid, inReady, res);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_rel: r=%b v=%b want 1 0", inReady, outValid);
        end
        issue(16'h4000, 16'hC200, lat);
        n_cmp++;
        if (lat !== LAT || res !== e) begin
            n_bad++;
            $display("FAIL rst_next: lat=%0d res=%h want %0d %h",
                     lat, res, LAT, e);
        end
        retire();
    endtask

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        mulIn1   = '0;
        mulIn2   = '0;
        test_reset();
        test_normal();
        test_exp_limits();
        test_zero();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
